// File: rtl/redirect_hazard_unit.sv
// Load-use / branch-in-ID hazard detection and forwarding-match flags for the redirect pipeline.
// Define REDIRECT_HAZ_STATS_EN to build the stall/flush statistics counters.
module redirect_hazard_unit #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_we,
    input  logic [RA_W-1:0]  id_wa,
    input  logic             id_memrd,
    input  logic             id_branch,
    input  logic             flush,
    output logic             stall,
    output logic             idsrc1ex,
    output logic             idsrc2ex,
    output logic             idsrc1mem,
    output logic             idsrc2mem,
    output logic             aluaeq,
    output logic             alubeq,
    output logic             memaeq,
    output logic             membeq,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic            ex_we, ex_memrd, mem_we, mem_memrd, wb_we;
    logic [RA_W-1:0] ex_wa, mem_wa, wb_wa;

    logic rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
    logic load_use, branch_haz;

    // Register 0 is hard-wired, so it never counts as a pending destination.
    function automatic logic match(input logic [RA_W-1:0] s, input logic we,
                                   input logic [RA_W-1:0] wa);
        return (s != '0) && we && (s == wa);
    endfunction

    always_comb begin
        rs_ex  = match(id_rs, ex_we, ex_wa);
        rt_ex  = match(id_rt, ex_we, ex_wa);
        rs_mem = match(id_rs, mem_we, mem_wa);
        rt_mem = match(id_rt, mem_we, mem_wa);
        rs_wb  = match(id_rs, wb_we, wb_wa);
        rt_wb  = match(id_rt, wb_we, wb_wa);

        load_use = id_valid && ex_memrd &&
                   ((id_use_rs && rs_ex) || (id_use_rt && rt_ex));

        // A branch compares in ID, so it must wait for ALU results in EX and load data in MEM.
        branch_haz = id_valid && id_branch &&
                     ((id_use_rs && (rs_ex || (rs_mem && mem_memrd))) ||
                      (id_use_rt && (rt_ex || (rt_mem && mem_memrd))));

        stall     = (load_use || branch_haz) && !flush;
        idsrc1ex  = rs_mem && !mem_memrd;
        idsrc2ex  = rt_mem && !mem_memrd;
        idsrc1mem = rs_wb;
        idsrc2mem = rt_wb;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_we     <= 1'b0;
            ex_wa     <= '0;
            ex_memrd  <= 1'b0;
            mem_we    <= 1'b0;
            mem_wa    <= '0;
            mem_memrd <= 1'b0;
            wb_we     <= 1'b0;
            wb_wa     <= '0;
            aluaeq    <= 1'b0;
            alubeq    <= 1'b0;
            memaeq    <= 1'b0;
            membeq    <= 1'b0;
        end else begin
            if (flush || stall) begin
                ex_we    <= 1'b0;
                ex_wa    <= '0;
                ex_memrd <= 1'b0;
                aluaeq   <= 1'b0;
                alubeq   <= 1'b0;
                memaeq   <= 1'b0;
                membeq   <= 1'b0;
            end else begin
                ex_we    <= id_valid && id_we;
                ex_wa    <= id_valid ? id_wa : '0;
                ex_memrd <= id_valid && id_memrd;
                aluaeq   <= id_use_rs && rs_ex;
                alubeq   <= id_use_rt && rt_ex;
                memaeq   <= id_use_rs && rs_mem;
                membeq   <= id_use_rt && rt_mem;
            end
            mem_we    <= ex_we;
            mem_wa    <= ex_wa;
            mem_memrd <= ex_memrd;
            wb_we     <= mem_we;
            wb_wa     <= mem_wa;
        end
    end

`ifdef REDIRECT_HAZ_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating counters: they stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
